// File: rtl/pdp8_iot_pkg.sv
// Shared types and constants for the PDP-8 IOT dispatch sequencer.
// Holds the sequencer state encoding, the IOT opcode and the IOP pulse bit positions.
package pdp8_iot_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StP1,
      StP2,
      StP4,
      StFinish
   } state_e;

   localparam logic [2:0] OP_IOT = 3'b110;

   localparam int unsigned IOP1_BIT = 0;
   localparam int unsigned IOP2_BIT = 1;
   localparam int unsigned IOP4_BIT = 2;

   // Lowest pending IOP bit wins; an empty mask goes straight to FINISH.
   function automatic state_e first_pulse(logic [2:0] mask);
      if (mask[IOP1_BIT]) return StP1;
      if (mask[IOP2_BIT]) return StP2;
      if (mask[IOP4_BIT]) return StP4;
      return StFinish;
   endfunction

endpackage

// File: rtl/iot_dispatch_sequencer_if.sv
// Control-side handshake plus peripheral-bus signals of the IOT dispatch sequencer.
// The slave modport is the sequencer; master is the control sequencer and device side.
interface iot_dispatch_sequencer_if #(
   parameter int unsigned NUM_DEV = 8
) ();

   logic               start;
   logic [11:0]        ir;
   logic [NUM_DEV-1:0] dev_skip;
   logic [NUM_DEV-1:0] dev_clrac;
   logic [NUM_DEV-1:0] dev_wait;
   logic [NUM_DEV-1:0] dev_sel;
   logic [2:0]         iop;
   logic               busy;
   logic               done;
   logic               skip;
   logic               clr_ac;
   logic               err;

   modport master (
      output start, ir, dev_skip, dev_clrac, dev_wait,
      input  dev_sel, iop, busy, done, skip, clr_ac, err
   );

   modport slave (
      input  start, ir, dev_skip, dev_clrac, dev_wait,
      output dev_sel, iop, busy, done, skip, clr_ac, err
   );

endinterface

// File: rtl/iot_pulse_timer.sv
// Per-pulse cycle counter shared by all IOP phases of the dispatch sequencer.
// Saturates at TIMEOUT-1 so a stuck wait cannot wrap back into a fresh pulse.
module iot_pulse_timer #(
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic base_done,
   output logic timeout
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CntW'(TIMEOUT - 1))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      base_done = (cnt_q >= CntW'(PULSE_CYCLES - 1));
      timeout   = (cnt_q == CntW'(TIMEOUT - 1));
   end

endmodule

// File: rtl/iot_dispatch_sequencer.sv
// PDP-8 IOT executor: latches an IOT, selects the addressed device and sequences
// IOP1/IOP2/IOP4 pulses with wait-stretch, timeout abort and sticky skip/clear-AC flags.
module iot_dispatch_sequencer
   import pdp8_iot_pkg::*;
#(
   parameter int unsigned NUM_DEV      = 8,
   parameter int unsigned DEV_BASE     = 0,
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 64
) (
   input logic                    clk,
   input logic                    reset,
   iot_dispatch_sequencer_if.slave bus
);

   state_e             state_q, state_d;
   logic [2:0]         iopbits_q, iopbits_d;
   logic [NUM_DEV-1:0] sel_q, sel_d;
   logic               skip_q, skip_d;
   logic               clrac_q, clrac_d;
   logic               err_q, err_d;

   logic [2:0] iop_q, iop_d;
   logic       busy_q, done_q, skip_out_q, clrac_out_q, err_out_q;

   logic       base_done, timeout, timer_clr, timer_en;
   logic       wait_sel, pulse_ok;
   logic [2:0] later;

   function automatic logic [NUM_DEV-1:0] decode(logic [5:0] code);
      logic [NUM_DEV-1:0] sel;
      sel = '0;
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
         sel[i] = (32'(code) == DEV_BASE + i);
      end
      return sel;
   endfunction

   always_comb begin
      wait_sel = |(bus.dev_wait & sel_q);
      pulse_ok = base_done && !wait_sel;
   end

   always_comb begin
      state_d   = state_q;
      iopbits_d = iopbits_q;
      sel_d     = sel_q;
      skip_d    = skip_q;
      clrac_d   = clrac_q;
      err_d     = err_q;
      later     = 3'b000;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               iopbits_d = bus.ir[2:0];
               if (bus.ir[11:9] != OP_IOT) begin
                  err_d   = 1'b1;
                  state_d = StFinish;
               end else begin
                  // Select is registered from the incoming IR so it is valid in DECODE.
                  sel_d   = decode(bus.ir[8:3]);
                  err_d   = ~|sel_d;
                  state_d = StDecode;
               end
            end
         end
         StDecode: begin
            state_d = first_pulse(iopbits_q);
         end
         StP1, StP2, StP4: begin
            if (state_q == StP1) later = 3'b110;
            if (state_q == StP2) later = 3'b100;
            if (pulse_ok || timeout) begin
               skip_d  = skip_q | (|(bus.dev_skip & sel_q));
               clrac_d = clrac_q | (|(bus.dev_clrac & sel_q));
               if (pulse_ok) begin
                  state_d = first_pulse(iopbits_q & later);
               end else begin
                  err_d   = 1'b1;
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            state_d   = StIdle;
            iopbits_d = '0;
            sel_d     = '0;
            skip_d    = 1'b0;
            clrac_d   = 1'b0;
            err_d     = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      iop_d           = 3'b000;
      iop_d[IOP1_BIT] = (state_d == StP1);
      iop_d[IOP2_BIT] = (state_d == StP2);
      iop_d[IOP4_BIT] = (state_d == StP4);
      timer_clr       = (state_d != state_q);
      timer_en        = (state_q == StP1) || (state_q == StP2) || (state_q == StP4);
   end

   iot_pulse_timer #(
      .PULSE_CYCLES (PULSE_CYCLES),
      .TIMEOUT      (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr       (timer_clr),
      .en        (timer_en),
      .base_done (base_done),
      .timeout   (timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         iopbits_q   <= '0;
         sel_q       <= '0;
         skip_q      <= 1'b0;
         clrac_q     <= 1'b0;
         err_q       <= 1'b0;
         iop_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         skip_out_q  <= 1'b0;
         clrac_out_q <= 1'b0;
         err_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         iopbits_q   <= iopbits_d;
         sel_q       <= sel_d;
         skip_q      <= skip_d;
         clrac_q     <= clrac_d;
         err_q       <= err_d;
         iop_q       <= iop_d;
         busy_q      <= (state_d != StIdle);
         done_q      <= (state_d == StFinish);
         skip_out_q  <= (state_d == StFinish) && skip_d;
         clrac_out_q <= (state_d == StFinish) && clrac_d;
         err_out_q   <= (state_d == StFinish) && err_d;
      end
   end

   assign bus.dev_sel = sel_q;
   assign bus.iop     = iop_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.skip    = skip_out_q;
   assign bus.clr_ac  = clrac_out_q;
   assign bus.err     = err_out_q;

endmodule

// File: tb/tb_iot_dispatch_sequencer.sv
// Self-checking bench for iot_dispatch_sequencer: expected completions are queued at start
// and compared against done, pulse counts and device selects as the DUT produces them.
module tb_iot_dispatch_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iot_dispatch_sequencer_if #(.NUM_DEV(8)) bus ();

   iot_dispatch_sequencer #(
      .NUM_DEV      (8),
      .DEV_BASE     (0),
      .PULSE_CYCLES (2),
      .TIMEOUT      (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [11:0] ir;
      int          c0;
      int          lat;
      logic [7:0]  sel;
      logic        skip;
      logic        clr;
      logic        err;
      int          n1;
      int          n2;
      int          n4;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   n1 = 0, n2 = 0, n4 = 0, sel_err = 0;

   // One negedge step: sample outputs and retire any completion against the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      total++;
      if ($countones(bus.iop) > 1) begin
         bad++;
         $display("FAIL iop_onehot cyc=%0d: iop=%b, required at most one bit", cyc, bus.iop);
      end
      if (bus.busy === 1'b1) begin
         n1 += int'(bus.iop[0]);
         n2 += int'(bus.iop[1]);
         n4 += int'(bus.iop[2]);
         if (exp_q.size() > 0 && bus.dev_sel !== exp_q[0].sel) sel_err++;
      end
      if (bus.done === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done cyc=%0d: done=1, required 0", cyc);
         end else begin
            e = exp_q.pop_front();
            if (cyc - e.c0 != e.lat) begin
               bad++;
               $display("FAIL latency ir=%o: got %0d, required %0d", e.ir, cyc - e.c0, e.lat);
            end
            total++;
            if (bus.skip !== e.skip) begin
               bad++;
               $display("FAIL skip ir=%o: got %b, required %b", e.ir, bus.skip, e.skip);
            end
            total++;
            if (bus.clr_ac !== e.clr) begin
               bad++;
               $display("FAIL clr_ac ir=%o: got %b, required %b", e.ir, bus.clr_ac, e.clr);
            end
            total++;
            if (bus.err !== e.err) begin
               bad++;
               $display("FAIL err ir=%o: got %b, required %b", e.ir, bus.err, e.err);
            end
            total++;
            if (n1 != e.n1 || n2 != e.n2 || n4 != e.n4) begin
               bad++;
               $display("FAIL iop_counts ir=%o: got %0d/%0d/%0d, required %0d/%0d/%0d",
                        e.ir, n1, n2, n4, e.n1, e.n2, e.n4);
            end
            total++;
            if (sel_err != 0) begin
               bad++;
               $display("FAIL dev_sel ir=%o: %0d busy cycles differed from %h",
                        e.ir, sel_err, e.sel);
            end
            total++;
            if (bus.iop !== 3'b000) begin
               bad++;
               $display("FAIL iop_at_done ir=%o: got %b, required 000", e.ir, bus.iop);
            end
         end
      end
      if (bus.busy !== 1'b1) begin
         n1 = 0; n2 = 0; n4 = 0; sel_err = 0;
      end
   endtask

   task automatic run_txn(input logic [11:0] ir, input logic [7:0] skp, input logic [7:0] clr,
                          input logic [7:0] wt, input int wait_last, input int spur1,
                          input int spur2, input int lat, input logic [7:0] sel,
                          input logic eskip, input logic eclr, input logic eerr,
                          input int e1, input int e2, input int e4);
      exp_t e;
      int   k;
      e = '{ir: ir, c0: cyc, lat: lat, sel: sel, skip: eskip, clr: eclr, err: eerr,
             n1: e1, n2: e2, n4: e4};
      exp_q.push_back(e);
      bus.ir        = ir;
      bus.start     = 1'b1;
      bus.dev_skip  = skp;
      bus.dev_clrac = clr;
      bus.dev_wait  = (wait_last >= 0) ? wt : 8'h00;
      repeat (300) begin
         tick();
         k = cyc - e.c0;
         bus.start = (k == spur1) || (k == spur2);
         if (bus.start) bus.ir = 12'o6032;
         bus.dev_wait = (k <= wait_last) ? wt : 8'h00;
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout ir=%o: no done within 300 cycles, required done", ir);
         exp_q.delete();
      end
      tick();
      bus.start     = 1'b0;
      bus.dev_skip  = '0;
      bus.dev_clrac = '0;
      bus.dev_wait  = '0;
      tick();
   endtask

   task automatic check_idle(input string name);
      total++;
      if ({bus.busy, bus.done, bus.iop, bus.dev_sel, bus.skip, bus.clr_ac, bus.err} !== '0) begin
         bad++;
         $display("FAIL %s: busy=%b done=%b iop=%b dev_sel=%h skip=%b clr_ac=%b err=%b, required 0",
                  name, bus.busy, bus.done, bus.iop, bus.dev_sel, bus.skip, bus.clr_ac, bus.err);
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.ir        = 12'o0000;
      bus.dev_skip  = '0;
      bus.dev_clrac = '0;
      bus.dev_wait  = '0;
      repeat (3) @(negedge clk);
      check_idle("reset_state");
      reset = 1'b0;
      tick();
      check_idle("idle_after_reset");
   endtask

   task automatic test_full_iot();
      run_txn(12'o6017, 8'h00, 8'h00, 8'h00, -1, -1, -1, 8, 8'h02, 0, 0, 0, 2, 2, 2);
      // Requests from devices that are not addressed must not stretch or flag anything.
      run_txn(12'o6017, 8'hFD, 8'hFD, 8'hFD, 1000, -1, -1, 8, 8'h02, 0, 0, 0, 2, 2, 2);
   endtask

   task automatic test_skip_clrac();
      run_txn(12'o6032, 8'h08, 8'h00, 8'h00, -1, -1, -1, 4, 8'h08, 1, 0, 0, 0, 2, 0);
      run_txn(12'o6032, 8'h04, 8'h00, 8'h00, -1, -1, -1, 4, 8'h08, 0, 0, 0, 0, 2, 0);
      run_txn(12'o6034, 8'h04, 8'h08, 8'h00, -1, -1, -1, 4, 8'h08, 0, 1, 0, 0, 0, 2);
   endtask

   task automatic test_wait_timeout();
      run_txn(12'o6011, 8'h00, 8'h00, 8'h02, 5, -1, -1, 7, 8'h02, 0, 0, 0, 5, 0, 0);
      run_txn(12'o6011, 8'h00, 8'h00, 8'h02, 1000, -1, -1, 66, 8'h02, 0, 0, 1, 64, 0, 0);
   endtask

   task automatic test_errors();
      run_txn(12'o6771, 8'h00, 8'h00, 8'h00, -1, -1, -1, 4, 8'h00, 0, 0, 1, 2, 0, 0);
      run_txn(12'o5000, 8'h00, 8'h00, 8'h00, -1, -1, -1, 1, 8'h00, 0, 0, 1, 0, 0, 0);
      run_txn(12'o6020, 8'h00, 8'h00, 8'h00, -1, -1, -1, 2, 8'h04, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      // Starts at c3 and on the done cycle c8 must both be dropped.
      run_txn(12'o6017, 8'h00, 8'h00, 8'h00, -1, 3, 8, 8, 8'h02, 0, 0, 0, 2, 2, 2);
      run_txn(12'o6025, 8'h00, 8'h00, 8'h00, -1, -1, -1, 6, 8'h04, 0, 0, 0, 2, 0, 2);
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen      = 1'b0;
      bus.ir    = 12'o6027;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) begin
         tick();
         if (bus.iop === 3'b010) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL reach_iop2: iop=%b, required 010 within 20 cycles", bus.iop);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("reset_mid_sequence");
      repeat (12) tick();
      check_idle("idle_after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_full_iot();
      test_skip_clrac();
      test_wait_timeout();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
